sys_op_sequencer: RTL and testbench
===================================

Name: sys_op_sequencer

Overview:
- Sequences privileged/system instructions (SRET, MRET, DRET, WFI, FENCE_VMA, FENCE_I) between decode and the CSR/commit unit.
- Accepts one system op at a time, together with the fault verdict from the privilege fault checker.
- Drains the pipeline, then either hands the op to the CSR unit or parks in WFI.
- Finishes every op (including faulting ones) with a fixed-length pipeline flush.

Parameters:
- XLEN, 64, width of instruction PC.
- FLUSH_CYCLES, 2, number of cycles flush_o is held per op; legal range 1..15.

Ports:
- clk  in  1  core clock.
- rstn  in  1  reset; asynchronous, active-low.
- in_valid_i  in  1  decode presents a system op.
- in_ready_o  out  1  sequencer can accept an op.
- in_op_i  in  3  op code: 0 NONE, 1 SRET, 2 MRET, 3 DRET, 4 WFI, 5 FENCE_VMA, 6 FENCE_I, 7 reserved (treated as NONE).
- in_fault_i  in  1  op is illegal in the current privilege/CSR context.
- in_pc_i  in  XLEN  PC of the op.
- pipe_empty_i  in  1  no older instructions in flight.
- irq_pending_i  in  1  enabled interrupt pending.
- debug_req_i  in  1  external debug request.
- exec_valid_o  out  1  request to the CSR unit to execute the latched op.
- exec_op_o  out  3  latched op.
- exec_pc_o  out  XLEN  latched PC.
- exec_done_i  in  1  CSR unit has completed the op.
- fault_valid_o  out  1  one-cycle illegal-instruction report.
- fault_pc_o  out  XLEN  PC of the faulting op (equal to exec_pc_o).
- flush_o  out  1  flush front-end and speculative state.
- wfi_o  out  1  core is stalled in WFI (clock-gate hint).
- wfi_cycles_o  out  32  cycles spent in the last or current WFI.
- busy_o  out  1  state is not IDLE.

Behaviour:
- Reset (rstn low, asynchronous):
  - State is IDLE; latched op, latched PC, flush counter and wfi_cycles_o are 0.
  - All other outputs are 0 except in_ready_o.
  - in_ready_o is 1 as soon as state is IDLE, including the first cycle after reset release.
- Control outputs (exec_valid_o, fault_valid_o, flush_o, wfi_o, busy_o, in_ready_o) are decoded from the registered state only; there is no combinational path from inputs to outputs.
- in_ready_o = (state == IDLE). Handshake is valid & ready at a rising edge; op, fault and PC are latched on that edge.
- States and transitions:
  - IDLE: on accept of NONE/reserved with no fault, consume and stay IDLE with no other effect. On accept with in_fault_i = 1, go to FAULT (a fault wins over any op code, including NONE). Otherwise go to DRAIN.
  - FAULT: fault_valid_o = 1 for exactly one cycle; next state FLUSH. exec_valid_o is never asserted for a faulting op.
  - DRAIN: hold until pipe_empty_i = 1 is sampled. Then WFI goes to WFI_WAIT; every other op goes to EXEC. irq_pending_i and debug_req_i are ignored in DRAIN.
  - EXEC: exec_valid_o = 1, held stable with exec_op_o and exec_pc_o until exec_done_i is sampled high; next state FLUSH. exec_done_i outside EXEC is ignored.
  - WFI_WAIT: wfi_o = 1. wfi_cycles_o is cleared on entry, then incremented every cycle spent in WFI_WAIT, saturating at 0xFFFFFFFF. Exit to FLUSH when irq_pending_i or debug_req_i is sampled high. A wake already present on entry still costs one WFI_WAIT cycle, so wfi_cycles_o ends at 1. wfi_cycles_o holds its value after exit.
  - FLUSH: flush_o = 1 for exactly FLUSH_CYCLES cycles via a down-counter loaded on entry; then IDLE.
- Latency:
  - Accept at edge T with pipe_empty_i high: exec_valid_o is high from cycle T+2.
  - Fault accepted at T: fault_valid_o high in cycle T+1 only; flush_o high in cycles T+2 .. T+1+FLUSH_CYCLES.
- Back-to-back ops: the next op can be accepted in the first IDLE cycle after FLUSH.
- Reset mid-operation: immediate abort to IDLE; no fault or flush is emitted for the aborted op.

Test Plan:
- MRET, fault = 0, pipe_empty_i = 1, exec_done_i at T+4, FLUSH_CYCLES = 2 -> exec_valid_o high T+2..T+4; flush_o high T+5..T+6; in_ready_o high at T+7.
- SRET with in_fault_i = 1, pc = 0x8000_0010 -> fault_valid_o high in T+1 only with fault_pc_o = 0x8000_0010; exec_valid_o never high; flush_o high for 2 cycles; back to IDLE.
- FENCE_VMA with pipe_empty_i low for 5 cycles after accept -> state stays DRAIN; exec_valid_o rises the cycle after pipe_empty_i is first sampled high.
- WFI, irq_pending_i asserted 10 cycles after entering WFI_WAIT -> wfi_o high 11 cycles; wfi_cycles_o = 11 and held; then flush.
- WFI with irq_pending_i already high -> wfi_o high 1 cycle; wfi_cycles_o = 1.
- NONE accepted, then rstn pulsed low during EXEC of a DRET -> NONE causes no state change; reset forces IDLE asynchronously, no flush_o/fault_valid_o, in_ready_o = 1 after release.

Source files
------------

// File: rtl/sys_op_sequencer.sv
// System-op sequencer: accepts one privileged op at a time, drains the pipeline,
// hands the op to the CSR unit or parks in WFI, and finishes with a fixed flush.
module sys_op_sequencer #(
  parameter int XLEN         = 64,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      in_op_i,
  input  logic            in_fault_i,
  input  logic [XLEN-1:0] in_pc_i,
  input  logic            pipe_empty_i,
  input  logic            irq_pending_i,
  input  logic            debug_req_i,
  output logic            exec_valid_o,
  output logic [2:0]      exec_op_o,
  output logic [XLEN-1:0] exec_pc_o,
  input  logic            exec_done_i,
  output logic            fault_valid_o,
  output logic [XLEN-1:0] fault_pc_o,
  output logic            flush_o,
  output logic            wfi_o,
  output logic [31:0]     wfi_cycles_o,
  output logic            busy_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FAULT = 3'd1,
    S_DRAIN = 3'd2,
    S_EXEC  = 3'd3,
    S_WFI   = 3'd4,
    S_FLUSH = 3'd5
  } state_t;

  localparam logic [2:0] OP_NONE     = 3'd0;
  localparam logic [2:0] OP_WFI      = 3'd4;
  localparam logic [2:0] OP_RESERVED = 3'd7;
  localparam logic [3:0] FLUSH_LOAD  = 4'(FLUSH_CYCLES - 1);

  state_t          state_q, state_d;
  logic [2:0]      op_q;
  logic [XLEN-1:0] pc_q;
  logic [3:0]      flush_cnt_q;
  logic [31:0]     wfi_cnt_q;
  logic            accept;
  logic            op_is_nop;

  // Handshake: an op transfers on a rising edge where in_valid_i && in_ready_o;
  // in_ready_o depends only on registered state, so valid may wait on ready.
  assign accept    = in_valid_i && (state_q == S_IDLE);
  assign op_is_nop = (in_op_i == OP_NONE) || (in_op_i == OP_RESERVED);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          if (in_fault_i)      state_d = S_FAULT;
          else if (!op_is_nop) state_d = S_DRAIN;
        end
      end
      S_FAULT: state_d = S_FLUSH;
      S_DRAIN: begin
        if (pipe_empty_i) state_d = (op_q == OP_WFI) ? S_WFI : S_EXEC;
      end
      S_EXEC:  if (exec_done_i) state_d = S_FLUSH;
      S_WFI:   if (irq_pending_i || debug_req_i) state_d = S_FLUSH;
      S_FLUSH: if (flush_cnt_q == 4'd0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_q <= 3'd0;
      pc_q <= '0;
    end else if (accept) begin
      op_q <= in_op_i;
      pc_q <= in_pc_i;
    end
  end

  // Flush counter is loaded on entry so FLUSH lasts FLUSH_CYCLES cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      flush_cnt_q <= 4'd0;
    end else if ((state_d == S_FLUSH) && (state_q != S_FLUSH)) begin
      flush_cnt_q <= FLUSH_LOAD;
    end else if ((state_q == S_FLUSH) && (flush_cnt_q != 4'd0)) begin
      flush_cnt_q <= flush_cnt_q - 4'd1;
    end
  end

  // WFI residency: cleared on entry, counts every WFI cycle, holds after exit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wfi_cnt_q <= 32'd0;
    end else if ((state_q == S_DRAIN) && (state_d == S_WFI)) begin
      wfi_cnt_q <= 32'd0;
    end else if ((state_q == S_WFI) && (wfi_cnt_q != 32'hFFFF_FFFF)) begin
      wfi_cnt_q <= wfi_cnt_q + 32'd1;
    end
  end

  assign in_ready_o    = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign fault_valid_o = (state_q == S_FAULT);
  assign exec_valid_o  = (state_q == S_EXEC);
  assign wfi_o         = (state_q == S_WFI);
  assign flush_o       = (state_q == S_FLUSH);
  assign exec_op_o     = op_q;
  assign exec_pc_o     = pc_q;
  assign fault_pc_o    = pc_q;
  assign wfi_cycles_o  = wfi_cnt_q;

endmodule

// File: tb/tb_sys_op_sequencer.sv
// Bench for sys_op_sequencer: randomized ops, expected output events queued
// from a timing model and compared by an independent monitor.
module tb_sys_op_sequencer;

  localparam int XLEN = 64;
  localparam int FC   = 2;
  localparam int W    = 134;

  localparam logic [2:0] K_FAULT = 3'd1;
  localparam logic [2:0] K_EXEC  = 3'd2;
  localparam logic [2:0] K_WFI   = 3'd3;
  localparam logic [2:0] K_FLUSH = 3'd4;
  localparam logic [2:0] K_IDLE  = 3'd5;

  logic            clk;
  logic            rstn;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [2:0]      in_op_i;
  logic            in_fault_i;
  logic [XLEN-1:0] in_pc_i;
  logic            pipe_empty_i;
  logic            irq_pending_i;
  logic            debug_req_i;
  logic            exec_valid_o;
  logic [2:0]      exec_op_o;
  logic [XLEN-1:0] exec_pc_o;
  logic            exec_done_i;
  logic            fault_valid_o;
  logic [XLEN-1:0] fault_pc_o;
  logic            flush_o;
  logic            wfi_o;
  logic [31:0]     wfi_cycles_o;
  logic            busy_o;

  logic [W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  sys_op_sequencer #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_op_i(in_op_i),
    .in_fault_i(in_fault_i), .in_pc_i(in_pc_i), .pipe_empty_i(pipe_empty_i),
    .irq_pending_i(irq_pending_i), .debug_req_i(debug_req_i),
    .exec_valid_o(exec_valid_o), .exec_op_o(exec_op_o), .exec_pc_o(exec_pc_o),
    .exec_done_i(exec_done_i), .fault_valid_o(fault_valid_o), .fault_pc_o(fault_pc_o),
    .flush_o(flush_o), .wfi_o(wfi_o), .wfi_cycles_o(wfi_cycles_o), .busy_o(busy_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] ev(input logic [2:0] k, input logic [2:0] op,
                                      input logic [63:0] pc, input int lat,
                                      input int len, input logic [31:0] x);
    logic [15:0] l16, n16;
    l16 = lat[15:0];
    n16 = len[15:0];
    return {k, op, pc, l16, n16, x};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic string kname(input logic [2:0] k);
    case (k)
      K_FAULT: return "fault_event";
      K_EXEC:  return "exec_event";
      K_WFI:   return "wfi_event";
      K_FLUSH: return "flush_event";
      K_IDLE:  return "idle_return";
      default: return "unknown_event";
    endcase
  endfunction

  task automatic got_ev(input logic [W-1:0] act);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_%s: got %h required none", kname(act[W-1 -: 3]), act);
    end else begin
      e = exp_q.pop_front();
      chk(kname(e[W-1 -: 3]), act, e);
    end
  endtask

  // ---------------- driver ----------------
  // Expected events come from the op's timing rules: accept at edge T,
  // drain d cycles, done after e+1 exec cycles, wake after w+1 WFI cycles.
  task automatic run_op(input logic [2:0] op, input logic flt, input logic [63:0] pc,
                        input int d, input int e, input int w, input logic dbg);
    int n;
    int body;
    bool_blk: begin end
    n = 0;
    while (!in_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_o) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ready_timeout: got in_ready_o=0 required 1 within 200 cycles");
    end
    if (flt) begin
      exp_q.push_back(ev(K_FAULT, op, pc, 1, 1, 0));
      exp_q.push_back(ev(K_FLUSH, op, pc, 2, FC, 0));
      exp_q.push_back(ev(K_IDLE, op, pc, 2 + FC, 1 + FC, 0));
    end else if (op != 3'd0 && op != 3'd7) begin
      body = (op == 3'd4) ? w : e;
      if (op == 3'd4) exp_q.push_back(ev(K_WFI, op, pc, d + 2, w + 1, 32'(w + 1)));
      else            exp_q.push_back(ev(K_EXEC, op, pc, d + 2, e + 1, 0));
      exp_q.push_back(ev(K_FLUSH, op, pc, d + body + 3, FC, 0));
      exp_q.push_back(ev(K_IDLE, op, pc, d + body + 3 + FC, d + body + 2 + FC, 0));
    end
    in_valid_i = 1'b1;
    in_op_i    = op;
    in_fault_i = flt;
    in_pc_i    = pc;
    pipe_empty_i = $urandom_range(0, 1);
    if (op == 3'd4 && w == 0 && !flt) begin
      irq_pending_i = !dbg;
      debug_req_i   = dbg;
    end
    @(negedge clk);
    in_valid_i = 1'b0;
    in_op_i    = 3'($urandom_range(0, 7));
    in_fault_i = $urandom_range(0, 1);
    in_pc_i    = {$urandom, $urandom};
    if (!flt && op != 3'd0 && op != 3'd7) begin
      for (int i = 0; i <= d; i++) begin
        pipe_empty_i = (i == d);
        exec_done_i  = $urandom_range(0, 1);
        if (!(op == 3'd4 && w == 0)) begin
          irq_pending_i = $urandom_range(0, 1);
          debug_req_i   = $urandom_range(0, 1);
        end
        @(negedge clk);
      end
      pipe_empty_i = $urandom_range(0, 1);
      if (op == 3'd4) begin
        for (int j = 0; j <= w; j++) begin
          if (w > 0) begin
            irq_pending_i = (j == w) && !dbg;
            debug_req_i   = (j == w) && dbg;
          end
          exec_done_i = $urandom_range(0, 1);
          @(negedge clk);
        end
      end else begin
        for (int j = 0; j <= e; j++) begin
          exec_done_i   = (j == e);
          irq_pending_i = $urandom_range(0, 1);
          debug_req_i   = $urandom_range(0, 1);
          @(negedge clk);
        end
      end
      exec_done_i   = 1'b0;
      irq_pending_i = 1'b0;
      debug_req_i   = 1'b0;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int          mon_cyc = 0, mon_acc = 0;
  logic        p_f = 0, p_e = 0, p_w = 0, p_fl = 0, p_r = 1;
  int          f_st, f_len, e_st, e_len, w_st, w_len, fl_st, fl_len, b_len;
  int          e_unstable;
  logic [2:0]  e_op, f_op, w_op, fl_op;
  logic [63:0] e_pc, f_pc, w_pc, fl_pc;

  initial begin : monitor
    forever begin
      @(negedge clk);
      #1;
      mon_cyc++;
      if (!rstn) begin
        p_f = 0; p_e = 0; p_w = 0; p_fl = 0; p_r = 1; b_len = 0;
        continue;
      end
      if (fault_valid_o) begin
        if (!p_f) begin f_st = mon_cyc; f_len = 0; f_op = exec_op_o; f_pc = fault_pc_o; end
        f_len++;
      end else if (p_f) got_ev(ev(K_FAULT, f_op, f_pc, f_st - mon_acc, f_len, 0));
      if (exec_valid_o) begin
        if (!p_e) begin
          e_st = mon_cyc; e_len = 0; e_op = exec_op_o; e_pc = exec_pc_o; e_unstable = 0;
        end
        if (exec_op_o !== e_op || exec_pc_o !== e_pc) e_unstable++;
        e_len++;
      end else if (p_e) got_ev(ev(K_EXEC, e_op, e_pc, e_st - mon_acc, e_len, 32'(e_unstable)));
      if (wfi_o) begin
        if (!p_w) begin w_st = mon_cyc; w_len = 0; w_op = exec_op_o; w_pc = exec_pc_o; end
        w_len++;
      end else if (p_w) got_ev(ev(K_WFI, w_op, w_pc, w_st - mon_acc, w_len, wfi_cycles_o));
      if (flush_o) begin
        if (!p_fl) begin fl_st = mon_cyc; fl_len = 0; fl_op = exec_op_o; fl_pc = exec_pc_o; end
        fl_len++;
      end else if (p_fl) got_ev(ev(K_FLUSH, fl_op, fl_pc, fl_st - mon_acc, fl_len, 0));
      if (busy_o) b_len++;
      if (in_ready_o && !p_r) got_ev(ev(K_IDLE, exec_op_o, exec_pc_o, mon_cyc - mon_acc, b_len, 0));
      if (in_ready_o) b_len = 0;
      p_f = fault_valid_o; p_e = exec_valid_o; p_w = wfi_o; p_fl = flush_o; p_r = in_ready_o;
      if (in_valid_i && in_ready_o) mon_acc = mon_cyc;
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int n;
    rstn = 1'b0;
    in_valid_i = 0; in_op_i = 0; in_fault_i = 0; in_pc_i = '0;
    pipe_empty_i = 0; irq_pending_i = 0; debug_req_i = 0; exec_done_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", W'(in_ready_o), W'(1'b1));
    chk("rst_busy", W'(busy_o), W'(1'b0));
    chk("rst_exec_valid", W'(exec_valid_o), W'(1'b0));
    chk("rst_fault_valid", W'(fault_valid_o), W'(1'b0));
    chk("rst_flush", W'(flush_o), W'(1'b0));
    chk("rst_wfi", W'(wfi_o), W'(1'b0));
    chk("rst_wfi_cycles", W'(wfi_cycles_o), W'(32'd0));
    chk("rst_exec_op", W'(exec_op_o), W'(3'd0));
    chk("rst_exec_pc", W'(exec_pc_o), W'(64'd0));
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", W'(in_ready_o), W'(1'b1));

    run_op(3'd2, 1'b0, 64'h0000_0000_8000_1000, 0, 2, 0, 1'b0);   // MRET
    run_op(3'd1, 1'b1, 64'h0000_0000_8000_0010, 0, 0, 0, 1'b0);   // faulting SRET
    run_op(3'd5, 1'b0, 64'h0000_0000_8000_2000, 5, 1, 0, 1'b0);   // FENCE_VMA, slow drain
    run_op(3'd4, 1'b0, 64'h0000_0000_8000_3000, 0, 0, 10, 1'b0);  // WFI, late irq
    run_op(3'd4, 1'b0, 64'h0000_0000_8000_4000, 2, 0, 0, 1'b1);   // WFI, wake present
    run_op(3'd6, 1'b0, 64'h0000_0000_8000_5000, 1, 0, 0, 1'b0);   // FENCE_I
    run_op(3'd0, 1'b0, 64'h0000_0000_8000_6000, 0, 0, 0, 1'b0);   // NONE
    chk("none_in_ready", W'(in_ready_o), W'(1'b1));
    chk("none_busy", W'(busy_o), W'(1'b0));

    // DRET aborted by reset while in EXEC
    in_valid_i = 1'b1; in_op_i = 3'd3; in_fault_i = 1'b0;
    in_pc_i = 64'h0000_0000_8000_7000; pipe_empty_i = 1'b1;
    @(negedge clk);
    in_valid_i = 1'b0;
    @(negedge clk);
    chk("dret_exec_valid", W'(exec_valid_o), W'(1'b1));
    chk("dret_busy", W'(busy_o), W'(1'b1));
    #2 rstn = 1'b0;
    #1;
    chk("abort_in_ready", W'(in_ready_o), W'(1'b1));
    chk("abort_exec_valid", W'(exec_valid_o), W'(1'b0));
    chk("abort_flush", W'(flush_o), W'(1'b0));
    chk("abort_fault", W'(fault_valid_o), W'(1'b0));
    chk("abort_exec_op", W'(exec_op_o), W'(3'd0));
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("abort_rel_in_ready", W'(in_ready_o), W'(1'b1));
    chk("abort_rel_flush", W'(flush_o), W'(1'b0));

    for (int k = 0; k < 40; k++) begin
      run_op(3'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0), {$urandom, $urandom},
             $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 6),
             1'($urandom_range(0, 1)));
    end

    n = 0;
    while (!in_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("exp_q_drained", W'(exp_q.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
